alu_cmd_sequencer: RTL and testbench
====================================

# alu_cmd_sequencer

Command sequencer that sits directly upstream of the 32-bit ALU. It owns an 8-entry × 32-bit register file and accepts one command at a time over a valid/ready handshake. It either loads an immediate into a register, or reads two source registers, drives the ALU's A/B/opcode inputs, and writes the ALU result back to a destination register. Each completed command produces a one-cycle response pulse.

## Interface
Parameters:
- DATA_W, 32, datapath width; must match the ALU operand width
- ADDR_W, 3, register-file address width (2**ADDR_W entries)

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
- cmd_load  in  1  1 = write cmd_imm to cmd_dst; 0 = ALU operation
- cmd_op  in  3  ALU opcode, passed unmodified to alu_op
- cmd_src_a  in  ADDR_W  register index for ALU operand A
- cmd_src_b  in  ADDR_W  register index for ALU operand B
- cmd_dst  in  ADDR_W  destination register index
- cmd_imm  in  DATA_W  immediate value for load commands
- alu_a  out  DATA_W  registered; connects to ALU input A
- alu_b  out  DATA_W  registered; connects to ALU input B
- alu_op  out  3  registered; connects to ALU opcode
- alu_result  in  DATA_W  combinational result from the ALU
- rsp_valid  out  1  one-cycle pulse: command complete
- rsp_data  out  DATA_W  value written by the completed command
- rsp_dst  out  ADDR_W  register written by the completed command
- busy  out  1  equals ~cmd_ready
- rd_addr  in  ADDR_W  debug read address
- rd_data  out  DATA_W  combinational contents of rf[rd_addr]

## Operation
- **FSM states:** IDLE, EXEC, RESP.
- **Accept:** a command is accepted on a rising edge where cmd_valid & cmd_ready. Command fields are sampled only on that edge. cmd_valid while not ready is ignored and is not queued.
- **IDLE, load accepted:**
  - rf[cmd_dst] <= cmd_imm.
  - rsp_data <= cmd_imm, rsp_dst <= cmd_dst, rsp_valid <= 1.
  - Next state is RESP.
- **IDLE, ALU command accepted:**
  - alu_a <= rf[cmd_src_a], alu_b <= rf[cmd_src_b], alu_op <= cmd_op.
  - Internal dst_q <= cmd_dst.
  - Next state is EXEC.
- **EXEC:** the ALU evaluates combinationally from the registered operands. On the edge:
  - rf[dst_q] <= alu_result.
  - rsp_data <= alu_result, rsp_dst <= dst_q, rsp_valid <= 1.
  - Next state is RESP.
- **RESP:** rsp_valid is high for this cycle only. On the edge, rsp_valid <= 0 and the next state is IDLE.
- **Holding values:** alu_a, alu_b, alu_op, rsp_data and rsp_dst hold their last values until overwritten.
- **Operand aliasing:**
  - src_a == src_b is legal.
  - dst equal to a source is legal; the operands were latched at accept, so the old value is used.
- **Arithmetic:** the sequencer performs none. Results are taken verbatim from the ALU, which wraps modulo 2^32.
- **rd_data:** combinational. It reflects a register write from the cycle after the writing edge onward.
- **Reset:** on an edge with rst_n low:
  - state = IDLE.
  - All rf entries, alu_a, alu_b, alu_op, dst_q, rsp_data, rsp_dst and rsp_valid = 0.
  - Reset has priority over any accept or write on the same edge.
  - A command in flight is discarded with no write-back and no response.

## Timing
- **Outputs after reset:** cmd_ready = 1, busy = 0, rsp_valid = 0, all data outputs 0.
- **Load latency:** accept on edge N; rsp_valid is high in cycle N+1; cmd_ready returns high in cycle N+2.
- **ALU latency:**
  - Accept on edge N; operands appear on alu_a/alu_b/alu_op in cycle N+1 (EXEC).
  - Write-back on edge N+1; rsp_valid is high in cycle N+2; cmd_ready returns high in cycle N+3.
- **Throughput:** one load per 2 cycles, one ALU command per 3 cycles.
- **Critical path:** one register-to-register pass through the ALU, in EXEC only.

## Test plan
- **Reset:** hold rst_n low for 2 cycles -> cmd_ready = 1, rsp_valid = 0, alu_a/alu_b/alu_op = 0, rd_data = 0 for all 8 addresses.
- **Load then add:** load r1 = 5, r2 = 3, then ALU op 000 (src 1, 2, dst 3) -> in EXEC, alu_a = 5, alu_b = 3, alu_op = 000. Two cycles after accept, rsp_valid pulses once with rsp_data = 8 and rsp_dst = 3, and rd_data(3) = 8.
- **Wrap-around:**
  - Load r4 = 0xFFFFFFFF; op 110 (A+1, src_a 4, dst 4) -> rsp_data = 0 and r4 = 0.
  - op 100 (A-1) on r0 = 0 -> 0xFFFFFFFF.
- **Underflow and aliasing:** with r1 = 3 and r2 = 5, op 001 (src 1, 2, dst 1) -> rsp_data = 0xFFFFFFFE and r1 = 0xFFFFFFFE.
- **Back-to-back:** hold cmd_valid high across three ALU commands -> cmd_ready pattern 1,0,0,1,0,0,1. Each accepted exactly once, responses spaced 3 cycles apart.
- **Reset mid-operation:** drive rst_n low during EXEC -> no rsp_valid pulse, every register reads 0, cmd_ready = 1 in the cycle after reset is released.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of a combinational ALU: owns an 8x32 register file,
// executes load-immediate or two-operand ALU commands, and pulses a response per command.
module alu_cmd_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_src_a,
  input  logic [ADDR_W-1:0] cmd_src_b,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_dst,
  output logic              busy,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // Handshake: a command transfers on a rising edge where cmd_valid & cmd_ready;
  // cmd_ready is high only in IDLE and nothing offered while not ready is retained.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] rf [2**ADDR_W];
  logic [ADDR_W-1:0] dst_q;
  logic              accept;

  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;
  assign accept    = cmd_valid & cmd_ready;
  assign rd_data   = rf[rd_addr];

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = cmd_load ? RESP : EXEC;
      EXEC:    state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Operands are latched at accept, so a destination aliasing a source sees the old value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**ADDR_W; i++) rf[i] <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      dst_q     <= '0;
      rsp_data  <= '0;
      rsp_dst   <= '0;
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (cmd_load) begin
              rf[cmd_dst] <= cmd_imm;
              rsp_data    <= cmd_imm;
              rsp_dst     <= cmd_dst;
              rsp_valid   <= 1'b1;
            end else begin
              alu_a  <= rf[cmd_src_a];
              alu_b  <= rf[cmd_src_b];
              alu_op <= cmd_op;
              dst_q  <= cmd_dst;
            end
          end
        end
        EXEC: begin
          rf[dst_q] <= alu_result;
          rsp_data  <= alu_result;
          rsp_dst   <= dst_q;
          rsp_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a stub ALU, a transaction-level model of the register
// file and response timing, a per-cycle compare process, and literal spot checks.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_load = 1'b0;
  logic [2:0]  cmd_op = '0;
  logic [2:0]  cmd_src_a = '0;
  logic [2:0]  cmd_src_b = '0;
  logic [2:0]  cmd_dst = '0;
  logic [31:0] cmd_imm = '0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_dst;
  logic        busy;
  logic [2:0]  rd_addr = '0;
  logic [31:0] rd_data;

  alu_cmd_sequencer #(.DATA_W(32), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load), .cmd_op(cmd_op),
    .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_dst(rsp_dst), .busy(busy),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // rd_addr walks all eight registers continuously
  initial forever begin
    @(posedge clk);
    #2 rd_addr = rd_addr + 3'd1;
  end

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0: alu_fn = a + b;
      3'd1: alu_fn = a - b;
      3'd2: alu_fn = a & b;
      3'd3: alu_fn = a | b;
      3'd4: alu_fn = a - 32'd1;
      3'd5: alu_fn = a ^ b;
      3'd6: alu_fn = a + 32'd1;
      default: alu_fn = b;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_op);

  // ---------------- model state and scoreboard ----------------
  logic [31:0] model_rf [8];
  int          ready_from = 0;
  bit          chk_en = 1'b0;

  logic [31:0] exp_q[$];
  logic [2:0]  exp_dst_q[$];
  int          exp_cyc_q[$];
  logic [31:0] exec_a_q[$];
  logic [31:0] exec_b_q[$];
  logic [2:0]  exec_op_q[$];
  int          exec_cyc_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int rsp_count = 0;
  logic [31:0] last_rsp_data = '0;
  logic [2:0]  last_rsp_dst = '0;
  logic [31:0] last_exec_a = '0;
  logic [31:0] last_exec_b = '0;
  logic [2:0]  last_exec_op = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete(); exp_dst_q.delete(); exp_cyc_q.delete();
    exec_a_q.delete(); exec_b_q.delete(); exec_op_q.delete(); exec_cyc_q.delete();
    for (int i = 0; i < 8; i++) model_rf[i] = '0;
  endtask

  // ---------------- per-cycle compare ----------------
  initial forever begin
    bit exp_ready;
    bit exp_rv;
    @(negedge clk);
    if (chk_en) begin
      exp_ready = (cyc >= ready_from);
      check("cmd_ready", {31'd0, cmd_ready}, {31'd0, exp_ready});
      check("busy", {31'd0, busy}, {31'd0, ~exp_ready});
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
        check("rsp_missed", 32'd0, 32'd1);
        void'(exp_q.pop_front()); void'(exp_dst_q.pop_front()); void'(exp_cyc_q.pop_front());
      end
      exp_rv = (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc);
      check("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_rv});
      if (exp_rv) begin
        check("rsp_data", rsp_data, exp_q.pop_front());
        check("rsp_dst", {29'd0, rsp_dst}, {29'd0, exp_dst_q.pop_front()});
        void'(exp_cyc_q.pop_front());
      end
      if (rsp_valid) begin
        rsp_count++;
        last_rsp_data = rsp_data;
        last_rsp_dst  = rsp_dst;
      end
      if (exec_cyc_q.size() > 0 && exec_cyc_q[0] == cyc) begin
        check("alu_a", alu_a, exec_a_q.pop_front());
        check("alu_b", alu_b, exec_b_q.pop_front());
        check("alu_op", {29'd0, alu_op}, {29'd0, exec_op_q.pop_front()});
        void'(exec_cyc_q.pop_front());
        last_exec_a  = alu_a;
        last_exec_b  = alu_b;
        last_exec_op = alu_op;
      end
      if (exp_ready) check("rd_data", rd_data, model_rf[rd_addr]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input bit load, input logic [2:0] op, input logic [2:0] sa,
                       input logic [2:0] sb, input logic [2:0] dst, input logic [31:0] imm,
                       input bit keep);
    int e;
    logic [31:0] a;
    logic [31:0] b;
    do begin
      @(negedge clk);
      #1;
    end while (cyc < ready_from);
    cmd_valid = 1'b1;
    cmd_load  = load;
    cmd_op    = op;
    cmd_src_a = sa;
    cmd_src_b = sb;
    cmd_dst   = dst;
    cmd_imm   = imm;
    e = cyc + 1;
    if (load) begin
      exp_q.push_back(imm); exp_dst_q.push_back(dst); exp_cyc_q.push_back(e);
      ready_from = e + 1;
    end else begin
      a = model_rf[sa];
      b = model_rf[sb];
      exec_a_q.push_back(a); exec_b_q.push_back(b); exec_op_q.push_back(op);
      exec_cyc_q.push_back(e);
      exp_q.push_back(alu_fn(a, b, op)); exp_dst_q.push_back(dst); exp_cyc_q.push_back(e + 1);
      ready_from = e + 2;
    end
    @(posedge clk);
    #1;
    model_rf[dst] = load ? imm : alu_fn(a, b, op);
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    do begin
      @(negedge clk);
      #1;
    end while (cyc < ready_from);
  endtask

  // call at negedge+1; discards in-flight expectations and holds reset for two edges
  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    clear_model();
    ready_from = cyc + 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cnt0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset alu_a", alu_a, 32'd0);
    check("reset alu_b", alu_b, 32'd0);
    check("reset alu_op", {29'd0, alu_op}, 32'd0);
    check("reset rsp_data", rsp_data, 32'd0);
    ready_from = 0;
    #1 chk_en = 1'b1;
    repeat (8) @(negedge clk);
    #1 rst_n = 1'b1;

    // load then add
    issue(1'b1, 3'd0, 3'd0, 3'd0, 3'd1, 32'd5, 1'b0);
    issue(1'b1, 3'd0, 3'd0, 3'd0, 3'd2, 32'd3, 1'b0);
    issue(1'b0, 3'd0, 3'd1, 3'd2, 3'd3, 32'd0, 1'b0);
    wait_idle();
    check("add exec a", last_exec_a, 32'd5);
    check("add exec b", last_exec_b, 32'd3);
    check("add exec op", {29'd0, last_exec_op}, 32'd0);
    check("add rsp_data", last_rsp_data, 32'd8);
    check("add rsp_dst", {29'd0, last_rsp_dst}, 32'd3);

    // wrap-around
    issue(1'b1, 3'd0, 3'd0, 3'd0, 3'd4, 32'hFFFF_FFFF, 1'b0);
    issue(1'b0, 3'd6, 3'd4, 3'd4, 3'd4, 32'd0, 1'b0);
    wait_idle();
    check("inc wrap", last_rsp_data, 32'd0);
    issue(1'b0, 3'd4, 3'd0, 3'd0, 3'd5, 32'd0, 1'b0);
    wait_idle();
    check("dec wrap", last_rsp_data, 32'hFFFF_FFFF);

    // underflow with dst aliasing src_a, then read r1 back through pass-B
    issue(1'b1, 3'd0, 3'd0, 3'd0, 3'd1, 32'd3, 1'b0);
    issue(1'b1, 3'd0, 3'd0, 3'd0, 3'd2, 32'd5, 1'b0);
    issue(1'b0, 3'd1, 3'd1, 3'd2, 3'd1, 32'd0, 1'b0);
    wait_idle();
    check("sub underflow", last_rsp_data, 32'hFFFF_FFFE);
    issue(1'b0, 3'd7, 3'd0, 3'd1, 3'd6, 32'd0, 1'b0);
    wait_idle();
    check("r1 after alias", last_rsp_data, 32'hFFFF_FFFE);

    // back-to-back with cmd_valid held high
    cnt0 = rsp_count;
    issue(1'b0, 3'd0, 3'd1, 3'd2, 3'd7, 32'd0, 1'b1);
    issue(1'b0, 3'd5, 3'd7, 3'd4, 3'd6, 32'd0, 1'b1);
    issue(1'b0, 3'd3, 3'd6, 3'd2, 3'd5, 32'd0, 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);
    check("b2b rsp count", rsp_count - cnt0, 32'd3);

    // reset while in EXEC
    cnt0 = rsp_count;
    issue(1'b0, 3'd0, 3'd1, 3'd1, 3'd2, 32'd0, 1'b0);
    @(negedge clk);
    #1 do_reset();
    @(negedge clk);
    check("post-reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("mid-reset no rsp", rsp_count - cnt0, 32'd0);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      bit ld;
      ld = ($urandom_range(0, 9) < 3);
      issue(ld, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 2)) : $urandom(),
            ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 39) == 0 && !ld) begin
        @(negedge clk);
        #1 do_reset();
      end else if ($urandom_range(0, 3) == 0) begin
        cmd_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end
    end
    cmd_valid = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) check("leftover expectations", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
